// File: rtl/stopwatch_controller.sv
// Stopwatch control: per-button synchronize/debounce/edge-detect lanes feeding
// a five-state run/lap/pause/full FSM that drives the counter and display.

module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      // Level follows only after LAST+1 consecutive mismatching cycles.
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;
endmodule

module stopwatch_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_COUNT       = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic [13:0] count_value,
  output logic        count_enable,
  output logic        count_clear,
  output logic [13:0] display_value,
  output logic        lap_active,
  output logic        overflow
);
  localparam int NUM_BTN = 3;
  localparam logic [13:0] MAX = 14'(MAX_COUNT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] LAP   = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] FULL  = 3'd4;

  logic [NUM_BTN-1:0] raw, press;
  logic [2:0]         state, state_nxt;
  logic [13:0]        lap_reg, lap_nxt, display_nxt;
  logic               clr_nxt, capture, at_max;
  logic               sel_clr, sel_ss, sel_lap;

  assign raw = {btn_clear, btn_lap, btn_start_stop};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .press (press[i])
    );
  end

  // Only the highest-priority event of a cycle survives.
  assign sel_clr = press[2];
  assign sel_ss  = press[0] & ~press[2];
  assign sel_lap = press[1] & ~press[0] & ~press[2];
  assign at_max  = (count_value == MAX);

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE:  if (sel_ss) state_nxt = RUN;
      RUN: begin
        if (at_max)       state_nxt = FULL;
        else if (sel_ss)  state_nxt = PAUSE;
        else if (sel_lap) begin
          state_nxt = LAP;
          capture   = 1'b1;
        end
      end
      LAP: begin
        if (at_max)       state_nxt = FULL;
        else if (sel_ss)  state_nxt = PAUSE;
        else if (sel_lap) state_nxt = RUN;
      end
      PAUSE: begin
        if (sel_clr) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end else if (sel_ss) begin
          state_nxt = RUN;
        end
      end
      FULL: begin
        if (sel_clr) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display is computed from the next state so it lines up with lap_active/overflow.
  assign lap_nxt     = capture ? count_value : lap_reg;
  assign display_nxt = (state_nxt == LAP)  ? lap_nxt :
                       (state_nxt == FULL) ? MAX     : count_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      lap_reg       <= '0;
      display_value <= '0;
      count_clear   <= 1'b0;
    end else begin
      state         <= state_nxt;
      lap_reg       <= lap_nxt;
      display_value <= display_nxt;
      count_clear   <= clr_nxt;
    end
  end

  assign count_enable = ((state == RUN) || (state == LAP)) && !at_max;
  assign lap_active   = (state == LAP);
  assign overflow     = (state == FULL);
endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller with a short debounce: table of button
// presses plus hand sequences for bounce, saturation and reset corner cases.

module tb_stopwatch_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start_stop, btn_lap, btn_clear;
  logic [13:0] count_value;
  logic        count_enable, count_clear, lap_active, overflow;
  logic [13:0] display_value;

  int checks = 0;
  int errors = 0;

  stopwatch_controller #(.DEBOUNCE_CYCLES(4), .MAX_COUNT(9999)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .count_value    (count_value),
    .count_enable   (count_enable),
    .count_clear    (count_clear),
    .display_value  (display_value),
    .lap_active     (lap_active),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic        clr;
    logic        lap;
    logic        ovf;
    logic [13:0] disp;
  } exp_t;

  typedef struct {
    string       name;
    logic        ss;
    logic        lp;
    logic        cl;
    logic [13:0] cv;
    logic        en;
    logic        clr;
    logic        lap;
    logic        ovf;
    logic [13:0] disp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic en, input logic clr,
                            input logic lap, input logic ovf, input logic [13:0] disp);
    exp_t e;
    e.name = name; e.en = en; e.clr = clr; e.lap = lap; e.ovf = ovf; e.disp = disp;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (count_enable !== e.en || count_clear !== e.clr || lap_active !== e.lap ||
        overflow !== e.ovf || display_value !== e.disp) begin
      errors++;
      $display("FAIL %s: got en=%b clr=%b lap=%b ovf=%b disp=%0d, want en=%b clr=%b lap=%b ovf=%b disp=%0d",
               e.name, count_enable, count_clear, lap_active, overflow, display_value,
               e.en, e.clr, e.lap, e.ovf, e.disp);
    end
  endtask

  task automatic chk(input string name, input logic en, input logic clr,
                     input logic lap, input logic ovf, input logic [13:0] disp);
    expect_out(name, en, clr, lap, ovf, disp);
    check_out();
  endtask

  // Raw press to FSM update is 2 sync + 4 debounce + 1 edge-detect cycles.
  task automatic press(input logic s, input logic l, input logic c);
    btn_start_stop = s; btn_lap = l; btn_clear = c;
    cyc(7);
  endtask

  task automatic release_all();
    btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cyc(10);
  endtask

  initial begin
    //          name          ss    lp    cl    cv     en    clr   lap   ovf   disp
    vecs[0]  = '{"idle_ss",   1'b1, 1'b0, 1'b0, 14'd0,   1'b1, 1'b0, 1'b0, 1'b0, 14'd0};
    vecs[1]  = '{"run_ss",    1'b1, 1'b0, 1'b0, 14'd50,  1'b0, 1'b0, 1'b0, 1'b0, 14'd50};
    vecs[2]  = '{"pause_lap", 1'b0, 1'b1, 1'b0, 14'd50,  1'b0, 1'b0, 1'b0, 1'b0, 14'd50};
    vecs[3]  = '{"pause_ss",  1'b1, 1'b0, 1'b0, 14'd50,  1'b1, 1'b0, 1'b0, 1'b0, 14'd50};
    vecs[4]  = '{"run_lap",   1'b0, 1'b1, 1'b0, 14'd123, 1'b1, 1'b0, 1'b1, 1'b0, 14'd123};
    vecs[5]  = '{"lap_clr",   1'b0, 1'b0, 1'b1, 14'd200, 1'b1, 1'b0, 1'b1, 1'b0, 14'd123};
    vecs[6]  = '{"lap_lap",   1'b0, 1'b1, 1'b0, 14'd200, 1'b1, 1'b0, 1'b0, 1'b0, 14'd200};
    vecs[7]  = '{"run_clr",   1'b0, 1'b0, 1'b1, 14'd210, 1'b1, 1'b0, 1'b0, 1'b0, 14'd210};
    vecs[8]  = '{"run_ss2",   1'b1, 1'b0, 1'b0, 14'd210, 1'b0, 1'b0, 1'b0, 1'b0, 14'd210};
    vecs[9]  = '{"pause_sc",  1'b1, 1'b0, 1'b1, 14'd210, 1'b0, 1'b1, 1'b0, 1'b0, 14'd210};
    vecs[10] = '{"idle_lap",  1'b0, 1'b1, 1'b0, 14'd0,   1'b0, 1'b0, 1'b0, 1'b0, 14'd0};
    vecs[11] = '{"idle_clr",  1'b0, 1'b0, 1'b1, 14'd0,   1'b0, 1'b0, 1'b0, 1'b0, 14'd0};
    vecs[12] = '{"idle_sl",   1'b1, 1'b1, 1'b0, 14'd5,   1'b1, 1'b0, 1'b0, 1'b0, 14'd5};
    vecs[13] = '{"run_lc",    1'b0, 1'b1, 1'b1, 14'd7,   1'b1, 1'b0, 1'b0, 1'b0, 14'd7};
    vecs[14] = '{"run_sl",    1'b1, 1'b1, 1'b0, 14'd9,   1'b0, 1'b0, 1'b0, 1'b0, 14'd9};

    rst_n = 1'b0;
    btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    count_value = 14'd0;
    cyc(3);
    chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 14'd0);
    rst_n = 1'b1;
    cyc(2);

    // Bouncing start_stop: event counted from the final rising toggle.
    btn_start_stop = 1'b1; cyc(1);
    btn_start_stop = 1'b0; cyc(1);
    btn_start_stop = 1'b1; cyc(1);
    btn_start_stop = 1'b0; cyc(1);
    btn_start_stop = 1'b1;
    cyc(6);
    chk("bounce_before", 1'b0, 1'b0, 1'b0, 1'b0, 14'd0);
    cyc(1);
    chk("bounce_event", 1'b1, 1'b0, 1'b0, 1'b0, 14'd0);
    cyc(8);
    chk("bounce_single", 1'b1, 1'b0, 1'b0, 1'b0, 14'd0);
    release_all();
    press(1'b1, 1'b0, 1'b0); release_all();
    press(1'b0, 1'b0, 1'b1); release_all();

    for (int i = 0; i < 15; i++) begin
      count_value = vecs[i].cv;
      press(vecs[i].ss, vecs[i].lp, vecs[i].cl);
      chk(vecs[i].name, vecs[i].en, vecs[i].clr, vecs[i].lap, vecs[i].ovf, vecs[i].disp);
      cyc(4);
      release_all();
    end
    chk("clear_pulse_gone", 1'b0, 1'b0, 1'b0, 1'b0, 14'd9);

    // Saturation into FULL.
    press(1'b1, 1'b0, 1'b0);
    chk("resume", 1'b1, 1'b0, 1'b0, 1'b0, 14'd9);
    release_all();
    count_value = 14'd9998; cyc(1);
    chk("near_max", 1'b1, 1'b0, 1'b0, 1'b0, 14'd9998);
    count_value = 14'd9999; #1;
    chk("max_comb_en", 1'b0, 1'b0, 1'b0, 1'b0, 14'd9998);
    cyc(1);
    chk("full", 1'b0, 1'b0, 1'b0, 1'b1, 14'd9999);
    press(1'b1, 1'b0, 1'b0);
    chk("full_ss_ign", 1'b0, 1'b0, 1'b0, 1'b1, 14'd9999);
    release_all();
    press(1'b0, 1'b0, 1'b1);
    chk("full_clear", 1'b0, 1'b1, 1'b0, 1'b0, 14'd9999);
    cyc(1);
    chk("full_clear_1cyc", 1'b0, 1'b0, 1'b0, 1'b0, 14'd9999);
    release_all();

    // Reset during LAP with lap mid-debounce.
    count_value = 14'd0;
    press(1'b1, 1'b0, 1'b0); release_all();
    count_value = 14'd300;
    press(1'b0, 1'b1, 1'b0);
    chk("lap_again", 1'b1, 1'b0, 1'b1, 1'b0, 14'd300);
    release_all();
    btn_lap = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 14'd0);
    rst_n = 1'b1;
    btn_lap = 1'b0;
    cyc(10);
    chk("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 14'd300);

    // start_stop held through reset release.
    btn_start_stop = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("held_rst_wait", 1'b0, 1'b0, 1'b0, 1'b0, 14'd300);
    cyc(1);
    chk("held_rst_event", 1'b1, 1'b0, 1'b0, 1'b0, 14'd300);
    release_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
